// File: rtl/tc_timer.sv
// rtl/tc_timer.sv - memory-mapped countdown timer with IRQ; define TIMER_PRESCALE_EN to add a COUNT prescaler at addr 3
module tc_timer #(
    parameter int PRESET_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          addr,
    input  logic                WE,
    input  logic [31:0]         WD,
    output logic [31:0]         RD,
    output logic                IRQ
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t                r_state;
    logic                  r_en;
    logic [1:0]            r_mode;
    logic                  r_im;
    logic                  r_irq_flag;
    logic [PRESET_W-1:0]   r_preset;
    logic [PRESET_W-1:0]   r_count;
    logic                  w_ctrl_wr;
    logic                  w_step;

    assign w_ctrl_wr = WE && (addr == 2'd0);
    assign IRQ       = r_im & r_irq_flag;

`ifdef TIMER_PRESCALE_EN
    logic [15:0] r_prescale;
    logic [15:0] r_div;

    assign w_step = (r_div == r_prescale);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale <= 16'd0;
            r_div      <= 16'd0;
        end else begin
            if (WE && (addr == 2'd3))
                r_prescale <= WD[15:0];
            if ((r_state == S_CNT) && r_en && !w_step)
                r_div <= r_div + 16'd1;
            else
                r_div <= 16'd0;
        end
    end
`else
    assign w_step = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_en       <= 1'b0;
            r_mode     <= 2'd0;
            r_im       <= 1'b0;
            r_irq_flag <= 1'b0;
            r_preset   <= '0;
            r_count    <= '0;
        end else begin
            if (WE && (addr == 2'd1))
                r_preset <= WD[PRESET_W-1:0];

            case (r_state)
                S_IDLE: begin
                    if (r_en)
                        r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_count <= r_preset;
                    r_state <= S_CNT;
                end
                S_CNT: begin
                    if (!r_en) begin
                        r_state <= S_IDLE;
                    end else if (w_step) begin
                        if (r_count > PRESET_W'(1)) begin
                            r_count <= r_count - PRESET_W'(1);
                        end else begin
                            r_count    <= '0;
                            r_irq_flag <= 1'b1;
                            r_state    <= S_INT;
                        end
                    end
                end
                S_INT: begin
                    // Only MODE==1 reloads; the reserved encodings fall back to one-shot.
                    if (r_mode == 2'd1) begin
                        r_irq_flag <= 1'b0;
                        r_state    <= S_LOAD;
                    end else begin
                        r_en    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Placed last so a CTRL store overrides the one-shot EN clear and any flag update.
            if (w_ctrl_wr) begin
                r_en       <= WD[0];
                r_mode     <= WD[2:1];
                r_im       <= WD[3];
                r_irq_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        RD = 32'd0;
        case (addr)
            2'd0: RD = {28'd0, r_im, r_mode, r_en};
            2'd1: RD = 32'(r_preset);
            2'd2: RD = 32'(r_count);
            2'd3: begin
`ifdef TIMER_PRESCALE_EN
                RD = {16'd0, r_prescale};
`else
                RD = 32'd0;
`endif
            end
            default: RD = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_tc_timer.sv
// tb/tb_tc_timer.sv - scoreboard bench for tc_timer
module tb_tc_timer;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    tc_timer #(.PRESET_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .WE    (WE),
        .WD    (WD),
        .RD    (RD),
        .IRQ   (IRQ)
    );

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        irq;
    } chk_t;

    chk_t q[$];
    int   checks = 0;
    int   errors = 0;
    event ev_sample;

    // Mode-1 PRESET=3 sequences sampled after each edge following the CTRL write
    logic [31:0] cnt1 [21] = '{0,0,3,2,1,0,0,3,2,1,0,0,3,2,1,0,0,3,2,1,0};
    logic        irq1 [21] = '{0,0,0,0,0,1,0,0,0,0,1,0,0,0,0,1,0,0,0,0,1};
    logic [31:0] cnt2 [21] = '{3,3,3,2,1,0,0,3,2,1,0,0,3,2,1,0,0,3,2,1,0};
`ifdef TIMER_PRESCALE_EN
    logic [31:0] ps_cnt [10] = '{0,0,2,2,2,1,1,1,0,0};
    logic        ps_irq [10] = '{0,0,0,0,0,0,0,0,1,1};
    logic [31:0] p0_cnt [5]  = '{0,0,2,1,0};
    logic        p0_irq [5]  = '{0,0,0,0,1};
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : monitor
        chk_t it;
        forever begin
            @(negedge clk or ev_sample);
            if (q.size() > 0) begin
                it = q.pop_front();
                checks++;
                if (RD !== it.rd) begin
                    errors++;
                    $display("FAIL %s: RD got %h expected %h", it.name, RD, it.rd);
                end
                checks++;
                if (IRQ !== it.irq) begin
                    errors++;
                    $display("FAIL %s: IRQ got %b expected %b", it.name, IRQ, it.irq);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        WD   = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic push(input logic [31:0] rd, input logic irq, input string nm);
        chk_t it;
        it.name = nm;
        it.rd   = rd;
        it.irq  = irq;
        q.push_back(it);
    endtask

    task automatic chk(input logic [1:0] a, input logic [31:0] rd, input logic irq, input string nm);
        addr = a;
        push(rd, irq, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input logic [1:0] a, input logic [31:0] rd, input logic irq, input string nm);
        addr = a;
        push(rd, irq, nm);
        ->ev_sample;
        #1;
    endtask

    initial begin : stim
        reset = 1'b1;
        WE    = 1'b0;
        addr  = 2'd0;
        WD    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int a = 0; a < 4; a++)
            chk(2'(a), 32'd0, 1'b0, $sformatf("rst_addr%0d", a));

        // one-shot, PRESET=5
        bus_write(2'd1, 32'd5);
        bus_write(2'd0, 32'h9);
        tick();
        tick();
        for (int k = 0; k < 5; k++)
            chk(2'd2, 32'(5 - k), 1'b0, $sformatf("os_cnt%0d", k));
        chk(2'd2, 32'd0, 1'b1, "os_int");
        chk(2'd0, 32'h8, 1'b1, "os_en_clr");
        bus_write(2'd0, 32'h8);
        chk(2'd0, 32'h8, 1'b0, "os_irq_clr");

        // auto-reload, PRESET=3, IM=1
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'hB);
        for (int k = 0; k < 21; k++)
            chk(2'd2, cnt1[k], irq1[k], $sformatf("ar_k%0d", k));

        // auto-reload with IM=0
        bus_write(2'd0, 32'h0);
        bus_write(2'd0, 32'h3);
        for (int k = 0; k < 21; k++)
            chk(2'd2, cnt2[k], 1'b0, $sformatf("ar_nim_k%0d", k));

        // PRESET=0 one-shot
        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h9);
        chk(2'd2, 32'd3, 1'b0, "p0_k0");
        chk(2'd2, 32'd3, 1'b0, "p0_k1");
        chk(2'd2, 32'd0, 1'b0, "p0_k2");
        chk(2'd2, 32'd0, 1'b1, "p0_k3");
        chk(2'd0, 32'h8, 1'b1, "p0_ctrl");

        // COUNT write ignored, then stop mid-count at 2
        bus_write(2'd1, 32'd5);
        bus_write(2'd0, 32'h9);
        tick();
        tick();
        bus_write(2'd2, 32'hFF);
        chk(2'd2, 32'd4, 1'b0, "cnt_wr_ign");
        bus_write(2'd0, 32'h8);
        chk(2'd2, 32'd2, 1'b0, "stop_hold0");
        chk(2'd2, 32'd2, 1'b0, "stop_hold1");
        chk(2'd2, 32'd2, 1'b0, "stop_hold2");
        chk(2'd0, 32'h8, 1'b0, "stop_ctrl");

        // async reset while IRQ is high in auto-reload
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'hB);
        repeat (5) tick();
        snap(2'd2, 32'd0, 1'b1, "pre_rst");
        reset = 1'b1;
        #1;
        snap(2'd0, 32'd0, 1'b0, "arst_a0");
        snap(2'd1, 32'd0, 1'b0, "arst_a1");
        #1;
        snap(2'd2, 32'd0, 1'b0, "arst_a2");
        snap(2'd3, 32'd0, 1'b0, "arst_a3");
        reset = 1'b0;
        tick();

`ifdef TIMER_PRESCALE_EN
        bus_write(2'd3, 32'd2);
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h9);
        for (int k = 0; k < 10; k++)
            chk(2'd2, ps_cnt[k], ps_irq[k], $sformatf("ps2_k%0d", k));
        chk(2'd3, 32'd2, 1'b1, "ps_rd");
        bus_write(2'd3, 32'd0);
        bus_write(2'd0, 32'h9);
        for (int k = 0; k < 5; k++)
            chk(2'd2, p0_cnt[k], p0_irq[k], $sformatf("ps0_k%0d", k));
`else
        bus_write(2'd3, 32'hFFFF);
        chk(2'd3, 32'd0, 1'b0, "a3_ign");
`endif

        tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending %0d expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
